// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: command handshake and operand-fetch bus of alu_ctrl.
// master = command source / memory responder, slave = alu_ctrl.
interface alu_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_addr,
        output mem_ack, mem_rdata,
        input  cmd_ready, mem_req, mem_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr,
        input  mem_ack, mem_rdata,
        output cmd_ready, mem_req, mem_addr
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: accumulator ALU sequencer IDLE->FETCH->EXEC->WB.
// Ports: clk, rst_n (async low), bus (alu_ctrl_if.slave: cmd_* and
// mem_*), alu_op/alu_a/alu_b to the ALU, alu_result/alu_cy back,
// acc, flags {S,Z,P,CY}, busy, done/err one-cycle pulses.
// Optional ALU_CTRL_TIMEOUT_EN: abort a fetch after TIMEOUT cycles.
module alu_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_cy,
    output logic [7:0] acc,
    output logic [3:0] flags,
    output logic       busy,
    output logic       done,
    output logic       err
);

    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("alu_ctrl: TIMEOUT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  res_q, res_d;
    logic        cy_q, cy_d;
    logic [7:0]  acc_q, acc_d;
    logic [3:0]  flags_q, flags_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
`ifdef ALU_CTRL_TIMEOUT_EN
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    function automatic logic is_unary(input logic [2:0] op);
        return op inside {3'b010, 3'b110, 3'b111};
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        res_d       = res_q;
        cy_d        = cy_q;
        acc_d       = acc_q;
        flags_d     = flags_q;
        cmd_ready_d = cmd_ready_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
`ifdef ALU_CTRL_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d        = bus.cmd_op;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (is_unary(bus.cmd_op)) begin
                        state_d  = EXEC;
                        alu_op_d = bus.cmd_op;
                        alu_a_d  = acc_q;
                        alu_b_d  = 8'h00;
                    end else begin
                        state_d    = FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = bus.cmd_addr;
                    end
`ifdef ALU_CTRL_TIMEOUT_EN
                    cnt_d = 4'd0;
`endif
                end
            end
            FETCH: begin
                // ack wins over a timeout landing on the same cycle
                if (bus.mem_ack) begin
                    state_d    = EXEC;
                    mem_req_d  = 1'b0;
                    mem_addr_d = 16'h0000;
                    alu_op_d   = op_q;
                    alu_a_d    = acc_q;
                    alu_b_d    = bus.mem_rdata;
                end
`ifdef ALU_CTRL_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_addr_d  = 16'h0000;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            EXEC: begin
                res_d   = alu_result;
                cy_d    = alu_cy;
                done_d  = 1'b1;
                state_d = WB;
            end
            WB: begin
                acc_d       = res_q;
                flags_d     = {res_q[7], res_q == 8'h00, ~^res_q, cy_q};
                state_d     = IDLE;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                alu_op_d    = 3'd0;
                alu_a_d     = 8'h00;
                alu_b_d     = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            res_q       <= 8'h00;
            cy_q        <= 1'b0;
            acc_q       <= 8'h00;
            flags_q     <= 4'b0000;
            cmd_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alu_op_q    <= 3'd0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
`ifdef ALU_CTRL_TIMEOUT_EN
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            res_q       <= res_d;
            cy_q        <= cy_d;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            cmd_ready_q <= cmd_ready_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
`ifdef ALU_CTRL_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign acc           = acc_q;
    assign flags         = flags_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef ALU_CTRL_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule
